alu_decode_stage: RTL and testbench

- Registered, parametrised ALU decode stage for the out-of-order core.
- Decodes ALUOp/funct3/funct7/opb5 into a widened ALU control code covering full RV32I plus optional RV32M, a functional-unit select and an illegal flag.
- Carries a ROB tag and uses valid/ready handshakes on both sides with a 2-entry skid buffer.
- Sits between rename/dispatch and the issue queues; supports pipeline flush.

---
 rtl/alu_pkg.sv | 78 +++++++
 rtl/alu_skid_buf.sv | 98 +++++++++
 rtl/alu_decode_stage.sv | 126 ++++++++++++
 tb/tb_alu_decode_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Package shared by the ALU decode stage and its skid buffer.
// Holds the widened ALU/MULDIV control codes, the main-decoder
// class constants, functional-unit selects, the decoded-op record
// and the occupancy states of the skid buffer.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 5;

  // ALU codes live in 0..9; MULDIV codes are 16 + funct3 so the
  // muldiv unit can use the low three bits directly.
  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_SRA    = 5'd4,
    ALU_SLT    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_XOR    = 5'd7,
    ALU_SLL    = 5'd8,
    ALU_SLTU   = 5'd9,
    MD_MUL     = 5'd16,
    MD_MULH    = 5'd17,
    MD_MULHSU  = 5'd18,
    MD_MULHU   = 5'd19,
    MD_DIV     = 5'd20,
    MD_DIVU    = 5'd21,
    MD_REM     = 5'd22,
    MD_REMU    = 5'd23
  } alu_ctrl_e;

  // Main-decoder classes carried on alu_op.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic UNIT_ALU    = 1'b0;
  localparam logic UNIT_MULDIV = 1'b1;

  // funct7 patterns that select a sub-family of operations.
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Decoded-op record. The ROB tag is appended by the stage itself
  // because its width is a parameter of that stage.
  typedef struct packed {
    alu_ctrl_e ctrl;
    logic      unit;
    logic      illegal;
  } alu_dec_t;

  // Occupancy of the output register plus skid entry.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Base RV32I mapping of funct3 when funct7 does not pick an
  // alternate operation.
  function automatic alu_ctrl_e alu_base_ctrl(input logic [2:0] f3);
    alu_ctrl_e c;
    case (f3)
      3'b000:  c = ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer: an output register plus one
// skid entry, with synchronous flush and reset.
// Ports:
//   clk_i, reset_i   clock and synchronous active-high reset
//   flush_i          drops every buffered entry (and any offered one)
//   in_valid_i/in_ready_o/in_data_i     upstream handshake + payload
//   out_valid_o/out_ready_i/out_data_o  downstream handshake + payload
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] outData_q, outData_d;
  logic [W-1:0] skidData_q, skidData_d;
  logic         inReady_q, inReady_d;
  logic         accept, drain;

  // Next-state logic. The ready output is registered, so the skid
  // entry only ever takes the single op already in flight when the
  // consumer stalls. When the output drains while an op arrives and
  // the skid is empty, the new op goes straight into the output
  // register to keep full throughput.
  always_comb begin
    state_d    = state_q;
    outData_d  = outData_q;
    skidData_d = skidData_q;
    accept     = in_valid_i && inReady_q;
    drain      = (state_q != SKID_EMPTY) && out_ready_i;

    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          outData_d = in_data_i;
          state_d   = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (drain && accept) begin
          outData_d = in_data_i;
        end else if (drain) begin
          state_d = SKID_EMPTY;
        end else if (accept) begin
          skidData_d = in_data_i;
          state_d    = SKID_FULL;
        end
      end
      SKID_FULL: begin
        if (drain) begin
          outData_d = skidData_q;
          state_d   = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase

    if (flush_i) begin
      state_d = SKID_EMPTY;
    end

    inReady_d = (state_d != SKID_FULL);
  end

  // State register; reset clears everything and holds ready low.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= SKID_EMPTY;
      outData_q  <= '0;
      skidData_q <= '0;
      inReady_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      outData_q  <= outData_d;
      skidData_q <= skidData_d;
      inReady_q  <= inReady_d;
    end
  end

  // Outputs are forced idle for the whole time reset is held, not
  // just from the first reset edge onwards.
  always_comb begin
    out_valid_o = !reset_i && (state_q != SKID_EMPTY);
    in_ready_o  = !reset_i && inReady_q;
    out_data_o  = reset_i ? '0 : outData_q;
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU decode stage between rename/dispatch and the issue
// queues. Decodes alu_op/funct3/funct7/opb5 into a widened ALU or
// MULDIV control code, a unit select and an illegal flag, and
// carries the ROB tag through a 2-entry skid buffer.
// Ports:
//   clk, reset, flush                 clock, sync reset, pipeline kill
//   in_valid/in_ready                 upstream handshake
//   opb5, funct3, funct7, alu_op      instruction fields to decode
//   in_tag                            ROB tag of the incoming op
//   out_valid/out_ready               downstream handshake
//   out_ctrl, out_unit, out_illegal   decoded result
//   out_tag                           ROB tag of the presented op
// CTRL_W must be at least 5 so every control code fits.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned CTRL_W = 5,
  parameter bit          EN_M   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              opb5,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [1:0]        alu_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_unit,
  output logic              out_illegal,
  output logic [TAG_W-1:0]  out_tag
);

  typedef struct packed {
    alu_dec_t         dec;
    logic [TAG_W-1:0] tag;
  } payload_t;

  alu_dec_t dec;
  payload_t inPayload, outPayload;

  // Combinational decode. I-type has no subtract, so funct7 only
  // matters for the shift-immediates; illegal encodings are squashed
  // to ctrl 0 / ALU so the ROB sees a clean exception op.
  always_comb begin
    dec.ctrl    = ALU_ADD;
    dec.unit    = UNIT_ALU;
    dec.illegal = 1'b0;

    case (alu_op)
      ALUOP_ADD: dec.ctrl = ALU_ADD;
      ALUOP_SUB: dec.ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        if (opb5) begin
          case (funct7)
            F7_BASE: dec.ctrl = alu_base_ctrl(funct3);
            F7_ALT: begin
              if (funct3 == 3'b000)      dec.ctrl    = ALU_SUB;
              else if (funct3 == 3'b101) dec.ctrl    = ALU_SRA;
              else                       dec.illegal = 1'b1;
            end
            F7_MULDIV: begin
              if (EN_M) begin
                dec.ctrl = alu_ctrl_e'({2'b10, funct3});
                dec.unit = UNIT_MULDIV;
              end else begin
                dec.illegal = 1'b1;
              end
            end
            default: dec.illegal = 1'b1;
          endcase
        end else begin
          case (funct3)
            3'b001: begin
              if (funct7 == F7_BASE) dec.ctrl    = ALU_SLL;
              else                   dec.illegal = 1'b1;
            end
            3'b101: begin
              if (funct7 == F7_BASE)     dec.ctrl    = ALU_SRL;
              else if (funct7 == F7_ALT) dec.ctrl    = ALU_SRA;
              else                       dec.illegal = 1'b1;
            end
            default: dec.ctrl = alu_base_ctrl(funct3);
          endcase
        end
      end
      default: dec.illegal = 1'b1;
    endcase

    if (dec.illegal) begin
      dec.ctrl = ALU_ADD;
      dec.unit = UNIT_ALU;
    end

    inPayload.dec = dec;
    inPayload.tag = in_tag;
  end

  alu_skid_buf #(
    .W($bits(payload_t))
  ) uSkid (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (inPayload),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (outPayload)
  );

  // Unpack the presented op onto the output ports.
  always_comb begin
    out_ctrl    = CTRL_W'(outPayload.dec.ctrl);
    out_unit    = outPayload.dec.unit;
    out_illegal = outPayload.dec.illegal;
    out_tag     = outPayload.tag;
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode vectors, backpressure
// ordering, flush and reset. A second instance with RV32M disabled
// shares the inputs.
module tb_alu_decode_stage;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       inValid;
  logic       opb5;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [1:0] aluOp;
  logic [5:0] inTag;
  logic       outReady;

  logic       inReady, outValid, outUnit, outIllegal;
  logic [4:0] outCtrl;
  logic [5:0] outTag;

  logic       nmInReady, nmOutValid, nmOutUnit, nmOutIllegal;
  logic [4:0] nmOutCtrl;
  logic [5:0] nmOutTag;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  alu_decode_stage #(.TAG_W(6), .CTRL_W(5), .EN_M(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(inValid), .in_ready(inReady),
    .opb5(opb5), .funct3(funct3), .funct7(funct7), .alu_op(aluOp),
    .in_tag(inTag),
    .out_valid(outValid), .out_ready(outReady),
    .out_ctrl(outCtrl), .out_unit(outUnit), .out_illegal(outIllegal),
    .out_tag(outTag)
  );

  alu_decode_stage #(.TAG_W(6), .CTRL_W(5), .EN_M(1'b0)) dutNoM (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(inValid), .in_ready(nmInReady),
    .opb5(opb5), .funct3(funct3), .funct7(funct7), .alu_op(aluOp),
    .in_tag(inTag),
    .out_valid(nmOutValid), .out_ready(outReady),
    .out_ctrl(nmOutCtrl), .out_unit(nmOutUnit), .out_illegal(nmOutIllegal),
    .out_tag(nmOutTag)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 ns
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op,
                               input logic b5, input logic [6:0] f7,
                               input logic [2:0] f3, input logic [5:0] tag);
    inValid = v;
    aluOp   = op;
    opb5    = b5;
    funct7  = f7;
    funct3  = f3;
    inTag   = tag;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One op accepted with out_ready high; checks the decoded result a
  // cycle later.
  task automatic decodeStep(input string name, input logic [1:0] op,
                            input logic b5, input logic [6:0] f7,
                            input logic [2:0] f3, input logic [5:0] tag,
                            input logic [4:0] expCtrl, input logic expUnit,
                            input logic expIll);
    applyStimulus(1'b1, op, b5, f7, f3, tag);
    tick();
    checkOutput({name, ".valid"},   {31'd0, outValid},   32'd1);
    checkOutput({name, ".ctrl"},    {27'd0, outCtrl},    {27'd0, expCtrl});
    checkOutput({name, ".unit"},    {31'd0, outUnit},    {31'd0, expUnit});
    checkOutput({name, ".illegal"}, {31'd0, outIllegal}, {31'd0, expIll});
    checkOutput({name, ".tag"},     {26'd0, outTag},     {26'd0, tag});
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    outReady = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 3'd0, 6'd0);

    // Reset state.
    tick();
    tick();
    checkOutput("rst.valid",   {31'd0, outValid},   32'd0);
    checkOutput("rst.ready",   {31'd0, inReady},    32'd0);
    checkOutput("rst.ctrl",    {27'd0, outCtrl},    32'd0);
    checkOutput("rst.tag",     {26'd0, outTag},     32'd0);
    checkOutput("rst.illegal", {31'd0, outIllegal}, 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("postrst.ready", {31'd0, inReady},  32'd1);
    checkOutput("postrst.valid", {31'd0, outValid}, 32'd0);

    // Decode vectors, streamed back to back at full throughput.
    decodeStep("r_sra",   2'b10, 1'b1, 7'b0100000, 3'b101, 6'd5, 5'd4,  1'b0, 1'b0);
    decodeStep("i_srai",  2'b10, 1'b0, 7'b0100000, 3'b101, 6'd6, 5'd4,  1'b0, 1'b0);
    decodeStep("i_sr_bad",2'b10, 1'b0, 7'b0000001, 3'b101, 6'd7, 5'd0,  1'b0, 1'b1);
    decodeStep("r_rem",   2'b10, 1'b1, 7'b0000001, 3'b110, 6'd8, 5'd22, 1'b1, 1'b0);
    checkOutput("nm_rem.illegal", {31'd0, nmOutIllegal}, 32'd1);
    checkOutput("nm_rem.ctrl",    {27'd0, nmOutCtrl},    32'd0);
    checkOutput("nm_rem.unit",    {31'd0, nmOutUnit},    32'd0);
    decodeStep("r_mul",   2'b10, 1'b1, 7'b0000001, 3'b000, 6'd9,  5'd16, 1'b1, 1'b0);
    decodeStep("r_divu",  2'b10, 1'b1, 7'b0000001, 3'b101, 6'd10, 5'd21, 1'b1, 1'b0);
    decodeStep("r_sll",   2'b10, 1'b1, 7'b0000000, 3'b001, 6'd11, 5'd8,  1'b0, 1'b0);
    decodeStep("r_sltu",  2'b10, 1'b1, 7'b0000000, 3'b011, 6'd12, 5'd9,  1'b0, 1'b0);
    decodeStep("r_sub",   2'b10, 1'b1, 7'b0100000, 3'b000, 6'd13, 5'd1,  1'b0, 1'b0);
    decodeStep("r_alt_bad",2'b10,1'b1, 7'b0100000, 3'b111, 6'd14, 5'd0,  1'b0, 1'b1);
    decodeStep("r_f7_bad",2'b10, 1'b1, 7'b0000010, 3'b000, 6'd15, 5'd0,  1'b0, 1'b1);
    decodeStep("i_addi",  2'b10, 1'b0, 7'b0100000, 3'b000, 6'd16, 5'd0,  1'b0, 1'b0);
    decodeStep("i_slli_bad",2'b10,1'b0,7'b0100000, 3'b001, 6'd17, 5'd0,  1'b0, 1'b1);
    decodeStep("i_srli",  2'b10, 1'b0, 7'b0000000, 3'b101, 6'd18, 5'd6,  1'b0, 1'b0);
    decodeStep("i_andi",  2'b10, 1'b0, 7'b1111111, 3'b111, 6'd19, 5'd2,  1'b0, 1'b0);
    decodeStep("op_sub",  2'b01, 1'b1, 7'b1111111, 3'b111, 6'd20, 5'd1,  1'b0, 1'b0);
    decodeStep("op_add",  2'b00, 1'b0, 7'b0000001, 3'b101, 6'd21, 5'd0,  1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 3'd0, 6'd0);
    tick();
    checkOutput("drain.valid", {31'd0, outValid}, 32'd0);

    // Backpressure: tag 1 loads, tag 2 goes to the skid, tag 3 waits.
    outReady = 1'b0;
    applyStimulus(1'b1, 2'b01, 1'b0, 7'd0, 3'd0, 6'd1);
    tick();
    checkOutput("bp1.tag",   {26'd0, outTag},  32'd1);
    checkOutput("bp1.ready", {31'd0, inReady}, 32'd1);
    applyStimulus(1'b1, 2'b00, 1'b0, 7'd0, 3'd0, 6'd2);
    tick();
    checkOutput("bp2.ready", {31'd0, inReady},  32'd0);
    checkOutput("bp2.tag",   {26'd0, outTag},   32'd1);
    checkOutput("bp2.ctrl",  {27'd0, outCtrl},  32'd1);
    applyStimulus(1'b1, 2'b00, 1'b0, 7'd0, 3'd0, 6'd3);
    tick();
    tick();
    checkOutput("bp_hold.tag",   {26'd0, outTag},   32'd1);
    checkOutput("bp_hold.ctrl",  {27'd0, outCtrl},  32'd1);
    checkOutput("bp_hold.valid", {31'd0, outValid}, 32'd1);
    checkOutput("bp_hold.ready", {31'd0, inReady},  32'd0);
    outReady = 1'b1;
    tick();
    checkOutput("bp_out2.tag",   {26'd0, outTag},   32'd2);
    checkOutput("bp_out2.ready", {31'd0, inReady},  32'd1);
    tick();
    checkOutput("bp_out3.tag",   {26'd0, outTag},   32'd3);
    checkOutput("bp_out3.valid", {31'd0, outValid}, 32'd1);
    applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 3'd0, 6'd0);
    tick();
    checkOutput("bp_end.valid", {31'd0, outValid}, 32'd0);

    // Flush with two ops buffered and tag 9 offered.
    outReady = 1'b0;
    applyStimulus(1'b1, 2'b00, 1'b0, 7'd0, 3'd0, 6'd10);
    tick();
    applyStimulus(1'b1, 2'b00, 1'b0, 7'd0, 3'd0, 6'd11);
    tick();
    checkOutput("fl_full.ready", {31'd0, inReady}, 32'd0);
    flush = 1'b1;
    applyStimulus(1'b1, 2'b00, 1'b0, 7'd0, 3'd0, 6'd9);
    tick();
    flush = 1'b0;
    checkOutput("fl.valid", {31'd0, outValid}, 32'd0);
    checkOutput("fl.ready", {31'd0, inReady},  32'd1);
    applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 3'd0, 6'd0);
    outReady = 1'b1;
    tick();
    checkOutput("fl_after.valid", {31'd0, outValid}, 32'd0);

    // Flush while the offered op would otherwise be accepted.
    applyStimulus(1'b1, 2'b00, 1'b0, 7'd0, 3'd0, 6'd12);
    tick();
    checkOutput("fl2_pre.tag", {26'd0, outTag}, 32'd12);
    flush = 1'b1;
    applyStimulus(1'b1, 2'b00, 1'b0, 7'd0, 3'd0, 6'd13);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 3'd0, 6'd0);
    checkOutput("fl2.valid", {31'd0, outValid}, 32'd0);
    checkOutput("fl2.ready", {31'd0, inReady},  32'd1);
    tick();
    checkOutput("fl2_after.valid", {31'd0, outValid}, 32'd0);

    // Reset with the skid full.
    outReady = 1'b0;
    applyStimulus(1'b1, 2'b00, 1'b0, 7'd0, 3'd0, 6'd20);
    tick();
    applyStimulus(1'b1, 2'b00, 1'b0, 7'd0, 3'd0, 6'd21);
    tick();
    checkOutput("rs_full.ready", {31'd0, inReady}, 32'd0);
    checkOutput("rs_full.valid", {31'd0, outValid}, 32'd1);
    reset = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 3'd0, 6'd0);
    #1;
    checkOutput("rs_during.valid", {31'd0, outValid}, 32'd0);
    checkOutput("rs_during.ready", {31'd0, inReady},  32'd0);
    tick();
    checkOutput("rs_edge.valid", {31'd0, outValid}, 32'd0);
    checkOutput("rs_edge.ready", {31'd0, inReady},  32'd0);
    reset = 1'b0;
    tick();
    checkOutput("rs_after.ready", {31'd0, inReady},  32'd1);
    checkOutput("rs_after.valid", {31'd0, outValid}, 32'd0);
    outReady = 1'b1;
    decodeStep("rsvd_op", 2'b11, 1'b1, 7'b0000000, 3'b000, 6'd30, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 7'd0, 3'd0, 6'd0);
    tick();
    checkOutput("final.valid", {31'd0, outValid}, 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
